// File: rtl/bin2bcd_param.sv
// bin2bcd_param: sequential binary-to-BCD converter (shift-and-add-3),
// one input bit per clock, with overflow detection and an optional
// post-conversion HOLD period.
//
// Build option: define BIN2BCD_SIGNED_EN to treat bin as two's complement.
// The magnitude is then converted and the sign is reported on neg.
// Without the macro, bin is unsigned and neg stays 0.
module bin2bcd_param #(
  parameter int BIN_W       = 15,
  parameter int DIGITS      = 5,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done_tick,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  neg
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? (($clog2(HOLD_CYCLES + 1) > 0) ? $clog2(HOLD_CYCLES + 1) : 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(BIN_W - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   shreg;
  logic [BCD_W-1:0]   digits;
  logic               ovf_work;
  logic               sign_work;
  logic [CNT_W-1:0]   bit_cnt;
  logic [HOLD_W-1:0]  hold_cnt;

  logic [BCD_W-1:0]   digits_adj;
  logic [BCD_W-1:0]   digits_next;
  logic [BIN_W-1:0]   shreg_next;
  logic               carry_out;
  logic [BIN_W-1:0]   mag;
  logic               sign_in;

  // Each BCD digit above 4 gets +3 so that the following doubling carries
  // correctly into the next digit; the add is 4-bit with no inter-digit carry.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int k = 0; k < DIGITS; k++) begin
      if (d[4*k +: 4] > 4'd4) begin
        r[4*k +: 4] = d[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // One double-dabble step: adjust digits, then shift {digits, shreg} left.
  // The bit leaving the top digit is the overflow carry.
  always_comb begin
    digits_adj = add3_digits(digits);
    {carry_out, digits_next, shreg_next} = {digits_adj, shreg, 1'b0};
  end

  // Operand conditioning at the accepting edge.
`ifdef BIN2BCD_SIGNED_EN
  // Two's complement input: convert the magnitude. The most negative value
  // negates to itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    sign_in = bin[BIN_W-1];
    mag     = sign_in ? ((~bin) + BIN_W'(1)) : bin;
  end
`else
  // Unsigned input: the operand is used as-is and the sign is always 0.
  always_comb begin
    sign_in = 1'b0;
    mag     = bin;
  end
`endif

  // Control FSM with the working datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done_tick <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
      neg       <= 1'b0;
      shreg     <= '0;
      digits    <= '0;
      ovf_work  <= 1'b0;
      sign_work <= 1'b0;
      bit_cnt   <= '0;
      hold_cnt  <= '0;
    end else begin
      done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg     <= mag;
            sign_work <= sign_in;
            digits    <= '0;
            ovf_work  <= 1'b0;
            bit_cnt   <= CNT_INIT;
            state     <= OP;
            ready     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        OP: begin
          digits   <= digits_next;
          shreg    <= shreg_next;
          ovf_work <= ovf_work | carry_out;
          bit_cnt  <= bit_cnt - 1'b1;
          if (bit_cnt == '0) begin
            // Last bit shifted: publish the result together with done_tick.
            state     <= DONE;
            done_tick <= 1'b1;
            bcd       <= digits_next;
            overflow  <= ovf_work | carry_out;
            neg       <= sign_work;
          end
        end
        DONE: begin
          if (HOLD_CYCLES > 0) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_param.sv
// Testbench for bin2bcd_param: two instances (5 digits/no hold, and
// 4 digits/3 hold cycles), random start/bin stimulus, an arithmetic
// reference model and a queue-based scoreboard per instance.
module tb_bin2bcd_param;

  localparam int BW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  genvar g;
  for (g = 0; g < 2; g++) begin : inst
    localparam int     D   = (g == 0) ? 5 : 4;
    localparam int     H   = (g == 0) ? 0 : 3;
    localparam longint LIM = (g == 0) ? 100000 : 10000;

    logic              reset_n;
    logic              start;
    logic [BW-1:0]     bin;
    logic              ready;
    logic              busy;
    logic              done_tick;
    logic [4*D-1:0]    bcd;
    logic              overflow;
    logic              neg;

    typedef struct packed {
      logic [4*D-1:0] bcd;
      logic           ovf;
      logic           neg;
      int             due;
    } exp_t;

    exp_t           q[$];
    int             edge_n = 0;
    int             busy_cnt = 0;
    logic           exp_ready = 1'b1;
    logic [4*D-1:0] last_bcd = '0;
    logic           last_ovf = 1'b0;
    logic           last_neg = 1'b0;
    int             n_done = 0;
    bit             fin = 1'b0;

    bin2bcd_param #(
      .BIN_W      (BW),
      .DIGITS     (D),
      .HOLD_CYCLES(H)
    ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .bin      (bin),
      .ready    (ready),
      .busy     (busy),
      .done_tick(done_tick),
      .bcd      (bcd),
      .overflow (overflow),
      .neg      (neg)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, g, $time, act, exp);
      end
    endtask

    // Reference: plain decimal arithmetic on the (magnitude of the) operand.
    function automatic exp_t model(input logic [BW-1:0] b);
      exp_t   r;
      longint v;
      longint m;
      r.neg = 1'b0;
      v = longint'(b);
`ifdef BIN2BCD_SIGNED_EN
      if (b[BW-1]) begin
        v = (longint'(1) << BW) - longint'(b);
        r.neg = 1'b1;
      end
`endif
      r.ovf = (v >= LIM);
      m = v % LIM;
      r.bcd = '0;
      for (int i = 0; i < D; i++) begin
        r.bcd[4*i +: 4] = 4'(m % 10);
        m = m / 10;
      end
      r.due = 0;
      return r;
    endfunction

    function automatic logic [BW-1:0] pick_bin();
      logic [BW-1:0] v;
      case ($urandom % 9)
        0:       v = '0;
        1:       v = '1;
        2:       v = BW'(LIM - 1);
        3:       v = BW'(LIM);
        4:       v = BW'(12345);
        5:       v = BW'(9999);
        6:       v = {1'b1, {(BW-1){1'b0}}};
        7:       v = {1'b0, {(BW-1){1'b1}}};
        default: v = BW'($urandom);
      endcase
      return v;
    endfunction

    // Stimulus: predicts acceptance and pushes expected results.
    initial begin
      exp_t e;
      int   rst_cnt;
      int   rst_events;
      rst_cnt    = 0;
      rst_events = 0;
      start      = 1'b0;
      bin        = '0;
      reset_n    = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      edge_n = 3;
      #1 reset_n = 1'b1;
      for (int n = 0; n < 1500; n++) begin
        @(posedge clk);
        edge_n++;
        if (reset_n && start && busy_cnt == 0) begin
          e = model(bin);
          e.due = edge_n + BW;
          q.push_back(e);
          busy_cnt = BW + 1 + H;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
        end
        exp_ready = (busy_cnt == 0);
        #1;
        if (rst_cnt > 0) begin
          rst_cnt--;
          if (rst_cnt == 0) reset_n = 1'b1;
        end else if (rst_events < 2 && n >= ((rst_events == 0) ? 600 : 1000) &&
                     busy_cnt > H + 3 && busy_cnt < BW) begin
          reset_n   = 1'b0;
          q.delete();
          busy_cnt  = 0;
          exp_ready = 1'b1;
          last_bcd  = '0;
          last_ovf  = 1'b0;
          last_neg  = 1'b0;
          rst_cnt   = 3;
          rst_events++;
        end
        bin = pick_bin();
        if (!reset_n || n >= 1460)
          start = 1'b0;
        else if (n >= 300 && n < 500)
          start = 1'b1;
        else
          start = (n < 300) ? ($urandom % 4 == 0) : ($urandom % 2 == 0);
      end
      chk("drain", 64'(q.size()), 64'(0));
      chk("any_done", 64'(n_done > 20), 64'(1));
      fin = 1'b1;
    end

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    initial begin
      exp_t e;
      logic exp_done;
      forever begin
        @(negedge clk);
        exp_done = (q.size() > 0) && (q[0].due == edge_n);
        chk("ready", 64'(ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(!exp_ready));
        chk("done_tick", 64'(done_tick), 64'(exp_done));
        if (exp_done) begin
          e = q.pop_front();
          last_bcd = e.bcd;
          last_ovf = e.ovf;
          last_neg = e.neg;
          n_done++;
        end
        chk("bcd", 64'(bcd), 64'(last_bcd));
        chk("overflow", 64'(overflow), 64'(last_ovf));
        chk("neg", 64'(neg), 64'(last_neg));
      end
    end
  end

  initial begin
    wait (inst[0].fin && inst[1].fin);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
